// File: rtl/enigma_pkg.sv
// rtl/enigma_pkg.sv - wiring tables, modular helpers and pipeline payload for enigma_core
package enigma_pkg;

    localparam int ALPHABET    = 26;
    localparam int NUM_WIRINGS = 5;
    localparam int N_ROT       = 3;
    localparam int SW          = $clog2(ALPHABET);
    localparam int SEL_W       = $clog2(NUM_WIRINGS);

    localparam logic [0:NUM_WIRINGS-1][0:ALPHABET-1][7:0] W_STR = {
        "EKMFLGDQVZNTOWYHXUSPAIBRCJ",
        "AJDKSIRUXBLHWTMCQGZNPYFVOE",
        "BDFHJLCPRTXVZNYEIWGAKMUSQO",
        "ESOVPZJAYQUIRHXLNFTGKDCMWB",
        "VZBRGITYUPSDNHLXAWMJQOFECK"
    };
    localparam logic [0:ALPHABET-1][7:0] REFL_STR = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
    localparam logic [NUM_WIRINGS-1:0][SW-1:0] NOTCH = {5'd25, 5'd9, 5'd21, 5'd4, 5'd16};

    typedef logic [NUM_WIRINGS-1:0][ALPHABET-1:0][SW-1:0] table_t;

    function automatic logic [SW-1:0] letter(input logic [7:0] ch);
        return SW'(ch - 8'd65);
    endfunction

    // Inverse table is derived from the forward strings so the two can never disagree.
    function automatic table_t build_w(input logic inverse);
        table_t t;
        t = '0;
        for (int s = 0; s < NUM_WIRINGS; s++) begin
            for (int i = 0; i < ALPHABET; i++) begin
                if (inverse) t[s][letter(W_STR[s][i])] = SW'(i);
                else         t[s][i] = letter(W_STR[s][i]);
            end
        end
        return t;
    endfunction

    localparam table_t W    = build_w(1'b0);
    localparam table_t WINV = build_w(1'b1);

    function automatic logic [SW-1:0] refl(input logic [SW-1:0] c);
        return letter(REFL_STR[c]);
    endfunction

    function automatic logic [SW-1:0] mod_add(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic [SW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (SW+1)'(ALPHABET)) s = s - (SW+1)'(ALPHABET);
        return s[SW-1:0];
    endfunction

    function automatic logic [SW-1:0] mod_sub(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic [SW:0] s;
        s = {1'b0, a} - {1'b0, b};
        if (a < b) s = s + (SW+1)'(ALPHABET);
        return s[SW-1:0];
    endfunction

    typedef struct packed {
        logic [SW-1:0]                symb;
        logic [N_ROT-1:0][SW-1:0]     pos;
        logic [N_ROT-1:0][SEL_W-1:0]  sel;
        logic                         err;
        logic                         valid;
    } payload_t;

    localparam int PAYLOAD_W = $bits(payload_t);

endpackage

// File: rtl/enigma_rotor_stage.sv
// rtl/enigma_rotor_stage.sv - one registered pass through a rotor slot, forward or back
module enigma_rotor_stage
    import enigma_pkg::*;
#(
    parameter bit BACK = 1'b0,
    parameter int SLOT = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_stall,
    input  logic [PAYLOAD_W-1:0] i_pl,
    output logic [PAYLOAD_W-1:0] o_pl
);

    payload_t         w_in;
    payload_t         r_out;
    logic [SW-1:0]    w_p;
    logic [SW-1:0]    w_idx;
    logic [SW-1:0]    w_map;
    logic [SEL_W-1:0] w_sel;

    assign w_in  = payload_t'(i_pl);
    assign w_p   = w_in.pos[SLOT];
    assign w_sel = w_in.sel[SLOT];
    assign w_idx = mod_add(w_in.symb, w_p);
    assign w_map = BACK ? WINV[w_sel][w_idx] : W[w_sel][w_idx];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out <= '0;
        end else if (!i_stall) begin
            r_out      <= w_in;
            r_out.symb <= mod_sub(w_map, w_p);
        end
    end

    assign o_pl = r_out;

endmodule

// File: rtl/enigma_core.sv
// rtl/enigma_core.sv - pipelined rotor cipher with odometer stepping and valid/ready flow control
module enigma_core
    import enigma_pkg::*;
#(
    parameter int NUM_ROTORS = N_ROT
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        cfg_load_i,
    input  logic [NUM_ROTORS*SEL_W-1:0] rotor_sel_i,
    input  logic [NUM_ROTORS*SW-1:0]    pos_init_i,
    input  logic [ALPHABET*SW-1:0]      plug_i,
    input  logic [SW-1:0]               in_symb_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    output logic [SW-1:0]               out_symb_o,
    output logic                        out_err_o,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [NUM_ROTORS*SW-1:0]    pos_o
);

    localparam int LAST = 2*NUM_ROTORS + 1;

    logic [NUM_ROTORS-1:0][SW-1:0]    r_pos;
    logic [NUM_ROTORS-1:0][SW-1:0]    w_pos_next;
    logic [NUM_ROTORS-1:0][SEL_W-1:0] r_sel;
    logic [ALPHABET-1:0][SW-1:0]      r_plug;
    logic [NUM_ROTORS-1:0]            w_adv;
    payload_t                         r_s0;
    payload_t                         r_refl;
    payload_t                         w_pl [0:LAST];
    logic                             w_stall;
    logic                             w_accept;
    logic                             w_in_err;
    logic                             r_out_valid;
    logic                             r_out_err;
    logic [SW-1:0]                    r_out_symb;

    assign w_stall    = r_out_valid && !out_ready_i;
    assign in_ready_o = !w_stall && !cfg_load_i;
    assign w_accept   = in_valid_i && in_ready_o;
    assign w_in_err   = in_symb_i >= SW'(ALPHABET);

    // Odometer: a carry out of slot k moves k+1; a middle slot sitting on its own notch moves too.
    always_comb begin
        w_adv      = '0;
        w_pos_next = r_pos;
        w_adv[0]   = 1'b1;
        for (int k = 1; k < NUM_ROTORS; k++)
            w_adv[k] = (r_pos[k-1] == NOTCH[r_sel[k-1]]);
        for (int k = 1; k < NUM_ROTORS-1; k++)
            if (r_pos[k] == NOTCH[r_sel[k]]) w_adv[k] = 1'b1;
        for (int k = 0; k < NUM_ROTORS; k++)
            if (w_adv[k]) w_pos_next[k] = mod_add(r_pos[k], SW'(1));
    end

    assign w_pl[0]            = r_s0;
    assign w_pl[NUM_ROTORS+1] = r_refl;

    for (genvar k = 0; k < NUM_ROTORS; k++) begin : g_fwd
        enigma_rotor_stage #(.BACK(1'b0), .SLOT(k)) u_stage (
            .i_clk(clk_i), .i_rst_n(rst_ni), .i_stall(w_stall),
            .i_pl(w_pl[k]), .o_pl(w_pl[k+1])
        );
    end

    for (genvar k = 0; k < NUM_ROTORS; k++) begin : g_back
        enigma_rotor_stage #(.BACK(1'b1), .SLOT(NUM_ROTORS-1-k)) u_stage (
            .i_clk(clk_i), .i_rst_n(rst_ni), .i_stall(w_stall),
            .i_pl(w_pl[NUM_ROTORS+1+k]), .o_pl(w_pl[NUM_ROTORS+2+k])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pos <= '0;
            for (int k = 0; k < NUM_ROTORS; k++) r_sel[k] <= SEL_W'(k);
            for (int i = 0; i < ALPHABET; i++) r_plug[i] <= SW'(i);
            r_s0        <= '0;
            r_refl      <= '0;
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            r_out_symb  <= '0;
        end else begin
            if (cfg_load_i) begin
                r_pos  <= pos_init_i;
                r_sel  <= rotor_sel_i;
                r_plug <= plug_i;
            end else if (w_accept && !w_in_err) begin
                r_pos <= w_pos_next;
            end
            if (!w_stall) begin
                r_s0.symb   <= w_in_err ? '0 : r_plug[in_symb_i];
                r_s0.pos    <= w_in_err ? r_pos : w_pos_next;
                r_s0.sel    <= r_sel;
                r_s0.err    <= w_in_err;
                r_s0.valid  <= w_accept;
                r_refl      <= w_pl[NUM_ROTORS];
                r_refl.symb <= refl(w_pl[NUM_ROTORS].symb);
                r_out_valid <= w_pl[LAST].valid;
                r_out_err   <= w_pl[LAST].valid && w_pl[LAST].err;
                r_out_symb  <= (w_pl[LAST].valid && !w_pl[LAST].err) ? r_plug[w_pl[LAST].symb] : '0;
            end
        end
    end

    assign out_valid_o = r_out_valid;
    assign out_err_o   = r_out_err;
    assign out_symb_o  = r_out_symb;
    assign pos_o       = r_pos;

endmodule

// File: doc/enigma_core.md
# enigma_core

Parametrised successor of the fixed three-rotor encoder pipeline. It performs substitution through NUM_ROTORS rotors, a reflector and a plugboard, with an internal odometer that steps the rotors, including the double-step. Rotor selection and start positions are runtime-loadable. Flow control is valid/ready with full backpressure. The block sits between the symbol source and the output formatter and replaces externally supplied rotor offsets.

## Interface
- ALPHABET, 26: symbol count; symbols are 0-based (A=0).
- NUM_ROTORS, 3: rotor slots; slot 0 is rightmost (fastest).
- NUM_WIRINGS, 5: wirings available in the package table.
- SW, $clog2(ALPHABET): symbol width.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous and active-low.
- cfg_load_i  in  1  loads rotor_sel_i, pos_init_i and plug_i.
- rotor_sel_i  in  NUM_ROTORS×$clog2(NUM_WIRINGS)  wiring index per slot.
- pos_init_i  in  NUM_ROTORS×SW  start position per slot.
- plug_i  in  ALPHABET×SW  plugboard map; must be an involution.
- in_symb_i  in  SW  plaintext symbol.
- in_valid_i  in  1  in_symb_i is valid.
- in_ready_o  out  1  block accepts a symbol this cycle.
- out_symb_o  out  SW  ciphertext symbol.
- out_err_o  out  1  input symbol was ≥ ALPHABET.
- out_valid_o  out  1  output is valid.
- out_ready_i  in  1  downstream accepts the output.
- pos_o  out  NUM_ROTORS×SW  current rotor positions.

## Operation
- Accept: in_valid_i && in_ready_o.
- Step on accept, before encoding:
  - slot 0 always advances;
  - slot k+1 advances if slot k is at its notch;
  - a middle slot k (0<k<NUM_ROTORS-1) at its own notch also advances (double-step).
- Step: positions wrap ALPHABET-1→0. The encoding of an accepted symbol uses the post-step positions.
- Forward through slot k: c = (W[sel_k][(c+p_k) mod A] − p_k) mod A.
- Reflector: c = REFL[c].
- Back through slot k, from k=NUM_ROTORS-1 down to 0: the same formula using the inverse table WINV.
- Plugboard is applied at input and at output.
- All mod A arithmetic uses SW+1-bit unsigned intermediates. A single conditional add or subtract of ALPHABET is sufficient; no division.
- Out-of-range symbol:
  - no rotor step;
  - flows through the pipeline with err set;
  - out_symb_o = 0, out_err_o = 1.
- cfg_load_i:
  - positions and selection update next cycle; in_ready_o = 0 that cycle;
  - cfg_load_i has priority over a simultaneous in_valid_i, and that symbol is not accepted;
  - symbols already in flight finish with the positions captured at their accept.
- Rotor positions are captured per symbol at stage 0 and travel down the pipeline with it.

## Timing
- Latency L = 2·NUM_ROTORS + 3 cycles from accept to out_valid_o (9 at default).
- Stage layout:
  - stage 0: step and input plugboard;
  - NUM_ROTORS forward stages;
  - reflector stage;
  - NUM_ROTORS back stages;
  - output plugboard stage.
- Throughput is 1 symbol per cycle when out_ready_i = 1.
- Backpressure:
  - global stall when out_valid_o && !out_ready_i; all stages hold;
  - in_ready_o = !stall && !cfg_load_i;
  - out_symb_o and out_err_o are stable while stalled.
- Reset, including mid-stream:
  - all valids = 0, all outputs 0;
  - positions 0, rotor_sel slot k = k, plugboard identity;
  - in-flight symbols are discarded.
- pos_o is registered and reflects steps one cycle after accept.

## Structure
- Package enigma_pkg holds:
  - W and WINV tables (NUM_WIRINGS×26): wirings I–V;
  - NOTCH per wiring: Q, E, V, J, Z;
  - REFL: reflector B;
  - function mod_add / mod_sub;
  - stage payload struct: symb, pos vector, sel vector, err, valid.
- One sub-module, enigma_rotor_stage, parameterised by direction. It is instantiated 2·NUM_ROTORS times in a generate loop.

## Test plan
- Rotors I-II-III (slot 0 = III), positions AAA, identity plugboard. Input AAAAA -> BDZGO; pos_o ends AAF.
- Positions A-D-U (slot 2..0). Three accepts -> pos_o sequence ADV, AEW, BFX (double-step).
- Hold out_ready_i = 0 for 5 cycles after the first out_valid_o, with 12 back-to-back inputs. Required: no loss, no duplication, outputs match the golden model, in_ready_o = 0 during the stall.
- in_symb_i = 30 between two valid symbols. Required: out_err_o = 1 and out_symb_o = 0 for that slot; positions advance only for the valid symbols.
- cfg_load_i together with in_valid_i. Required: that symbol is not accepted; the next accept uses the new positions; in-flight results are unchanged.
- Assert rst_ni with 4 symbols in flight. Required: out_valid_o = 0 immediately and pos_o = 0; the first post-reset result equals the fresh-reset golden value.
